// File: rtl/ps2_kbd_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_tx
// Purpose  : Device-side PS/2 keyboard transmitter; a byte FIFO feeds 11-bit
//            frames onto the PS/2 clock/data lines, honouring host inhibit.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_tx #(
  parameter int HALF_PERIOD = 2000,
  parameter int GAP_CYCLES  = 4000,
  parameter int FIFO_AW     = 4
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  input  logic       ps2_clk_in,
  output logic       ps2_clk_out,
  output logic       ps2_data_out
);

  localparam int DEPTH   = 2 ** FIFO_AW;
  localparam int CNT_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HALF_LAST   = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] SAMPLE_FROM = CW'(3);
  localparam logic [3:0]    LAST_BIT    = 4'd10;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_BIT_HI  = 3'd2;
  localparam logic [2:0] S_BIT_LO  = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;
  localparam logic [2:0] S_INHIBIT = 3'd5;

  logic             clk_meta_q, clk_sync_q;
  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [10:0]      frame_q, frame_d;
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [7:0]       mem_q [DEPTH];

  logic       push;
  logic       pop;
  logic [7:0] head;

  // Idles high so a reset never looks like a host inhibit.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
    end
  end

  assign push     = wr_en && !full_q;
  assign overflow = wr_en && full_q;
  assign head     = mem_q[rd_ptr_q[FIFO_AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[FIFO_AW] != rd_ptr_d[FIFO_AW]) &&
               (wr_ptr_d[FIFO_AW-1:0] == rd_ptr_d[FIFO_AW-1:0]);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wr_data;
    end
  end

  assign full  = full_q;
  assign empty = empty_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      frame_q   <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!empty_q && clk_sync_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        // Transmit order is frame_q[0] first: start, data LSB-first, odd parity, stop.
        frame_d   = {1'b1, ~^head, head, 1'b0};
        bit_idx_d = '0;
        state_d   = S_BIT_HI;
      end
      S_BIT_HI: begin
        if (cnt_q >= SAMPLE_FROM && !clk_sync_q && bit_idx_q < LAST_BIT) begin
          state_d = S_INHIBIT;
        end else if (cnt_q == HALF_LAST) begin
          state_d = S_BIT_LO;
        end
      end
      S_BIT_LO: begin
        if (cnt_q == HALF_LAST) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d = S_GAP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            state_d   = S_BIT_HI;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_IDLE;
      end
      S_INHIBIT: begin
        // Needs an unbroken run of high samples before the frame is retried.
        if (!clk_sync_q) cnt_d = '0;
        else if (cnt_q == GAP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    ps2_clk_out  = 1'b1;
    ps2_data_out = 1'b1;
    busy         = (state_q != S_IDLE);
    pop          = 1'b0;
    case (state_q)
      S_BIT_HI: ps2_data_out = frame_q[bit_idx_q];
      S_BIT_LO: begin
        ps2_clk_out  = 1'b0;
        ps2_data_out = frame_q[bit_idx_q];
        pop          = (cnt_q == HALF_LAST) && (bit_idx_q == LAST_BIT);
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
